size_up_fifo: RTL



---
 rtl/size_up_fifo_pkg.sv | 29 ++
 rtl/size_up_packer.sv | 57 +++++
 rtl/size_up_fifo.sv | 118 +++++++++++
 3 files changed

// File: rtl/size_up_fifo_pkg.sv
// Shared helpers and defaults for the narrow-to-wide packing FIFO.
package size_up_fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH       = 5;
  localparam int unsigned DEF_IN_WIDTH         = 8;
  localparam int unsigned DEF_RATIO            = 4;
  localparam int unsigned DEF_ALMOST_FULL_NUM  = 4;
  localparam int unsigned DEF_ALMOST_EMPTY_NUM = 4;

  // Ceiling log2, minimum 1 so a counter always has at least one bit.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned out_width(input int unsigned in_w,
                                            input int unsigned ratio);
    return in_w * ratio;
  endfunction

  function automatic bit ratio_legal(input int unsigned ratio);
    return (ratio == 2) || (ratio == 4) || (ratio == 8);
  endfunction

endpackage

// File: rtl/size_up_packer.sv
// Collects RATIO narrow words little-endian into one wide word and
// emits a push when the word completes or a flush closes it early.
module size_up_packer
  import size_up_fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH = DEF_IN_WIDTH,
  parameter int unsigned RATIO    = DEF_RATIO
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_WIDTH-1:0]          i_wr_data,
  input  logic                         i_wr_en,
  input  logic                         i_flush,
  input  logic                         i_full,
  output logic                         o_push,
  output logic [IN_WIDTH*RATIO-1:0]    o_push_data
);

  localparam int unsigned OUT_WIDTH = out_width(IN_WIDTH, RATIO);
  localparam int unsigned CNT_W     = log2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic [OUT_WIDTH-1:0] r_pack;
  logic [OUT_WIDTH-1:0] w_next_pack;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_flush;

  // Merge the accepted narrow word into its lane and decide whether to push.
  always_comb begin
    w_accept    = i_wr_en & ~i_full;
    w_last      = w_accept & (r_cnt == LAST_LANE);
    w_flush     = i_flush & ~i_full & ((r_cnt != '0) | w_accept);
    w_next_pack = r_pack;
    if (w_accept) w_next_pack[int'(r_cnt)*IN_WIDTH +: IN_WIDTH] = i_wr_data;
  end

  // A flush that coincides with a completing write yields just one push.
  assign o_push      = w_last | w_flush;
  assign o_push_data = w_next_pack;

  // Lane counter and pack register; both clear whenever a word leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pack <= '0;
    end else if (o_push) begin
      r_cnt  <= '0;
      r_pack <= '0;
    end else if (w_accept) begin
      r_cnt  <= r_cnt + 1'b1;
      r_pack <= w_next_pack;
    end
  end

endmodule

// File: rtl/size_up_fifo.sv
// Width-upsizing FIFO: narrow writes are packed into wide words and
// buffered in a 2**ADDR_WIDTH entry RAM read out one wide word at a time.
module size_up_fifo
  import size_up_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int unsigned IN_WIDTH         = DEF_IN_WIDTH,
  parameter int unsigned RATIO            = DEF_RATIO,
  parameter int unsigned ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
  parameter int unsigned ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_WIDTH-1:0]          wr_data,
  input  logic                         wr_en,
  input  logic                         wr_flush,
  output logic                         full,
  output logic                         almost_full,
  output logic [ADDR_WIDTH:0]          wr_water_level,
  input  logic                         rd_en,
  output logic [IN_WIDTH*RATIO-1:0]    rd_data,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [ADDR_WIDTH:0]          rd_water_level
);

  localparam int unsigned OUT_WIDTH = out_width(IN_WIDTH, RATIO);
  localparam int unsigned PTR_W     = ADDR_WIDTH;
  localparam int unsigned LVL_W     = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [LVL_W-1:0] L_DEPTH = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] L_AF    = LVL_W'(DEPTH - ALMOST_FULL_NUM);
  localparam logic [LVL_W-1:0] L_AE    = LVL_W'(ALMOST_EMPTY_NUM);

  if ((ADDR_WIDTH < 4) || (ADDR_WIDTH > 10)) begin : g_bad_addr_width
    $error("size_up_fifo: ADDR_WIDTH must be 4..10");
  end
  if ((IN_WIDTH < 1) || (IN_WIDTH > 64)) begin : g_bad_in_width
    $error("size_up_fifo: IN_WIDTH must be 1..64");
  end
  if (!ratio_legal(RATIO)) begin : g_bad_ratio
    $error("size_up_fifo: RATIO must be 2, 4 or 8");
  end

  logic [OUT_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic [OUT_WIDTH-1:0] r_rd_data;
  logic                 r_full;
  logic                 r_almost_full;
  logic                 r_empty;
  logic                 r_almost_empty;

  logic                 w_push;
  logic [OUT_WIDTH-1:0] w_push_data;
  logic                 w_pop;
  logic [LVL_W-1:0]     w_level_next;

  size_up_packer #(
    .IN_WIDTH (IN_WIDTH),
    .RATIO    (RATIO)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_wr_data   (wr_data),
    .i_wr_en     (wr_en),
    .i_flush     (wr_flush),
    .i_full      (r_full),
    .o_push      (w_push),
    .o_push_data (w_push_data)
  );

  // Next occupancy; flags are derived from it so they never lag the level.
  always_comb begin
    w_pop        = rd_en & ~r_empty;
    w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
  end

  // Storage array, written without reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // Pointers, read register, occupancy and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_rd_data      <= '0;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_level        <= w_level_next;
      r_full         <= (w_level_next == L_DEPTH);
      r_almost_full  <= (w_level_next >= L_AF);
      r_empty        <= (w_level_next == '0);
      r_almost_empty <= (w_level_next <= L_AE);
    end
  end

  assign full           = r_full;
  assign almost_full    = r_almost_full;
  assign empty          = r_empty;
  assign almost_empty   = r_almost_empty;
  assign rd_data        = r_rd_data;
  assign wr_water_level = r_level;
  assign rd_water_level = r_level;

endmodule
